// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a shared single-port memory.
// Grants are combinational (zero latency when uncontended); read data is
// returned to the owner of the read one cycle after its grant.
module mem_arbiter #(
  parameter int unsigned RR = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] m0_addr,
  input  logic        m0_rstrb,
  input  logic [3:0]  m0_wmask,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic [31:0] m1_addr,
  input  logic        m1_rstrb,
  input  logic [3:0]  m1_wmask,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    LAST_M0 = 1'b0,
    LAST_M1 = 1'b1
  } last_t;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_M0   = 2'd1,
    RD_M1   = 2'd2
  } rd_t;

  last_t last_q, last_d;
  rd_t   rd_q, rd_d;
  logic  req0, req1;

  // Request decode and grant selection; no grant while in reset.
  always_comb begin
    req0   = m0_rstrb || (m0_wmask != '0);
    req1   = m1_rstrb || (m1_wmask != '0);
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (resetn) begin
      if (RR != 0) begin
        if (req0 && req1) begin
          m0_gnt = (last_q == LAST_M1);
          m1_gnt = (last_q == LAST_M0);
        end else begin
          m0_gnt = req0;
          m1_gnt = req1;
        end
      end else begin
        m0_gnt = req0;
        m1_gnt = req1 && !req0;
      end
    end
  end

  // Memory-side mux: granted requester forwarded as-is, all zero otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_rstrb = m0_rstrb;
      mem_wdata = m0_wdata;
      mem_wmask = m0_wmask;
    end else if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_rstrb = m1_rstrb;
      mem_wdata = m1_wdata;
      mem_wmask = m1_wmask;
    end
  end

  // Next-state: pointer moves only on a grant; read owner tracked per cycle.
  always_comb begin
    last_d = last_q;
    rd_d   = RD_NONE;
    if (m0_gnt) begin
      last_d = LAST_M0;
      if (m0_rstrb) rd_d = RD_M0;
    end else if (m1_gnt) begin
      last_d = LAST_M1;
      if (m1_rstrb) rd_d = RD_M1;
    end
  end

  // State registers; reset hands the first tie to m0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_q <= LAST_M1;
      rd_q   <= RD_NONE;
    end else begin
      last_q <= last_d;
      rd_q   <= rd_d;
    end
  end

  // Read return; gating with resetn drops a read whose data lands during reset.
  always_comb begin
    m0_rvalid = resetn && (rd_q == RD_M0);
    m1_rvalid = resetn && (rd_q == RD_M1);
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin instance with a behavioural memory and
// a read-return scoreboard, plus a fixed-priority instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_rstrb, m1_rstrb;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  logic [31:0] f0_addr, f1_addr, f0_wdata, f1_wdata;
  logic        f0_rstrb, f1_rstrb;
  logic [3:0]  f0_wmask, f1_wmask;
  logic        f0_gnt, f1_gnt, f0_rvalid, f1_rvalid;
  logic [31:0] f0_rdata, f1_rdata;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [31:0] f_mem_rdata = 32'h600D_F00D;
  logic        f_mem_rstrb;
  logic [3:0]  f_mem_wmask;

  mem_arbiter #(.RR(1)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.RR(0)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_addr(f0_addr), .m0_rstrb(f0_rstrb), .m0_wmask(f0_wmask), .m0_wdata(f0_wdata),
    .m0_gnt(f0_gnt), .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata),
    .m1_addr(f1_addr), .m1_rstrb(f1_rstrb), .m1_wmask(f1_wmask), .m1_wdata(f1_wdata),
    .m1_gnt(f1_gnt), .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata),
    .mem_addr(f_mem_addr), .mem_rstrb(f_mem_rstrb), .mem_wdata(f_mem_wdata),
    .mem_wmask(f_mem_wmask), .mem_rdata(f_mem_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seed(input int i);
    return 32'hC0DE_0000 | (i << 8) | (i * 3);
  endfunction

  // Behavioural shared memory: one-cycle read latency, byte-masked writes.
  logic [31:0] mem [64];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  logic [31:0] exp_mem [64];

  typedef struct {
    int          due;
    bit          owner;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  // Read-return monitor: pops the scoreboard entry due this cycle.
  always @(negedge clk) begin
    bit          e0, e1;
    logic [31:0] ed;
    rd_exp_t     x;
    if (mon_en) begin
      e0 = 1'b0; e1 = 1'b0; ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        x  = sb.pop_front();
        e0 = !x.owner;
        e1 = x.owner;
        ed = x.data;
      end
      total += 4;
      if (m0_rvalid !== e0) begin bad++; $display("FAIL m0_rvalid cyc=%0d got=%b want=%b", cyc, m0_rvalid, e0); end
      if (m1_rvalid !== e1) begin bad++; $display("FAIL m1_rvalid cyc=%0d got=%b want=%b", cyc, m1_rvalid, e1); end
      if (m0_rdata !== (e0 ? ed : 32'h0)) begin bad++; $display("FAIL m0_rdata cyc=%0d got=%h want=%h", cyc, m0_rdata, e0 ? ed : 32'h0); end
      if (m1_rdata !== (e1 ? ed : 32'h0)) begin bad++; $display("FAIL m1_rdata cyc=%0d got=%h want=%h", cyc, m1_rdata, e1 ? ed : 32'h0); end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_rstrb = 1'b0; m0_wmask = '0; m0_wdata = '0;
    m1_addr = '0; m1_rstrb = 1'b0; m1_wmask = '0; m1_wdata = '0;
    f0_addr = '0; f0_rstrb = 1'b0; f0_wmask = '0; f0_wdata = '0;
    f1_addr = '0; f1_rstrb = 1'b0; f1_wmask = '0; f1_wdata = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    m0_rstrb = 1'b1; m0_addr = 32'h10;
    m1_wmask = 4'hF; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    repeat (3) begin
      #2;
      total += 4;
      if (m0_gnt !== 1'b0)     begin bad++; $display("FAIL rst_g0 got=%b want=0", m0_gnt); end
      if (m1_gnt !== 1'b0)     begin bad++; $display("FAIL rst_g1 got=%b want=0", m1_gnt); end
      if (mem_rstrb !== 1'b0)  begin bad++; $display("FAIL rst_rstrb got=%b want=0", mem_rstrb); end
      if (mem_wmask !== 4'h0)  begin bad++; $display("FAIL rst_wmask got=%h want=0", mem_wmask); end
      next_cycle();
    end
    idle_inputs();
    resetn = 1'b1;
    #2;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL rel_gnt got=%b want=00", {m0_gnt, m1_gnt}); end
    next_cycle();
  endtask

  task automatic test_first_tie();
    m0_rstrb = 1'b1; m0_addr = 32'h10;
    m1_rstrb = 1'b1; m1_addr = 32'h20;
    #2;
    total += 3;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL tie1_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    if (mem_addr !== 32'h10)        begin bad++; $display("FAIL tie1_addr got=%h want=10", mem_addr); end
    if (mem_rstrb !== 1'b1)         begin bad++; $display("FAIL tie1_rstrb got=%b want=1", mem_rstrb); end
    sb.push_back('{cyc + 1, 1'b0, exp_mem[4]});
    next_cycle();
    m0_addr = 32'h14;
    #2;
    total += 2;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL tie2_gnt got=%b want=01", {m0_gnt, m1_gnt}); end
    if (mem_addr !== 32'h20)        begin bad++; $display("FAIL tie2_addr got=%h want=20", mem_addr); end
    sb.push_back('{cyc + 1, 1'b1, exp_mem[8]});
    next_cycle();
    m1_rstrb = 1'b0; m1_addr = '0;
    #2;
    total += 2;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL tie3_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    if (mem_addr !== 32'h14)        begin bad++; $display("FAIL tie3_addr got=%h want=14", mem_addr); end
    sb.push_back('{cyc + 1, 1'b0, exp_mem[5]});
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [31:0] a0, a1;
    int n0, n1;
    bit want0;
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    a0 = 32'h00; a1 = 32'h80; n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      m0_rstrb = 1'b1; m0_addr = a0;
      m1_rstrb = 1'b1; m1_addr = a1;
      want0 = (i % 2 == 0);
      #2;
      total += 2;
      if ({m0_gnt, m1_gnt} !== {want0, !want0}) begin bad++; $display("FAIL alt_gnt i=%0d got=%b want=%b", i, {m0_gnt, m1_gnt}, {want0, !want0}); end
      if (mem_addr !== (want0 ? a0 : a1)) begin bad++; $display("FAIL alt_addr i=%0d got=%h want=%h", i, mem_addr, want0 ? a0 : a1); end
      if (m0_gnt) n0++;
      if (m1_gnt) n1++;
      if (want0) begin
        sb.push_back('{cyc + 1, 1'b0, exp_mem[a0[7:2]]});
        a0 += 4;
      end else begin
        sb.push_back('{cyc + 1, 1'b1, exp_mem[a1[7:2]]});
        a1 += 4;
      end
      next_cycle();
    end
    idle_inputs();
    total += 2;
    if (n0 !== 4) begin bad++; $display("FAIL alt_n0 got=%0d want=4", n0); end
    if (n1 !== 4) begin bad++; $display("FAIL alt_n1 got=%0d want=4", n1); end
    next_cycle();
  endtask

  task automatic test_byte_write();
    m1_wmask = 4'b0100; m1_addr = 32'h8; m1_wdata = 32'h11AB_2233;
    #2;
    total += 5;
    if ({m0_gnt, m1_gnt} !== 2'b01)  begin bad++; $display("FAIL bw_gnt got=%b want=01", {m0_gnt, m1_gnt}); end
    if (mem_wmask !== 4'b0100)       begin bad++; $display("FAIL bw_wmask got=%b want=0100", mem_wmask); end
    if (mem_addr !== 32'h8)          begin bad++; $display("FAIL bw_addr got=%h want=8", mem_addr); end
    if (mem_wdata !== 32'h11AB_2233) begin bad++; $display("FAIL bw_wdata got=%h want=11ab2233", mem_wdata); end
    if (mem_rstrb !== 1'b0)          begin bad++; $display("FAIL bw_rstrb got=%b want=0", mem_rstrb); end
    exp_mem[2][23:16] = 8'hAB;
    next_cycle();
    idle_inputs();
    m0_rstrb = 1'b1; m0_addr = 32'h8;
    #2;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL br_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    sb.push_back('{cyc + 1, 1'b0, exp_mem[2]});
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_abort();
    m0_rstrb = 1'b1; m0_addr = 32'h18;
    #2;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL ab_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    next_cycle();
    idle_inputs();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    m0_rstrb = 1'b1; m0_addr = 32'h20;
    m1_rstrb = 1'b1; m1_addr = 32'h24;
    #2;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL ab_tie got=%b want=10", {m0_gnt, m1_gnt}); end
    sb.push_back('{cyc + 1, 1'b0, exp_mem[8]});
    next_cycle();
    m0_rstrb = 1'b0; m0_addr = '0;
    #2;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL ab_m1 got=%b want=01", {m0_gnt, m1_gnt}); end
    sb.push_back('{cyc + 1, 1'b1, exp_mem[9]});
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_idle();
    idle_inputs();
    repeat (4) begin
      #2;
      total += 5;
      if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL idle_gnt got=%b want=00", {m0_gnt, m1_gnt}); end
      if (mem_rstrb !== 1'b0)         begin bad++; $display("FAIL idle_rstrb got=%b want=0", mem_rstrb); end
      if (mem_wmask !== 4'h0)         begin bad++; $display("FAIL idle_wmask got=%h want=0", mem_wmask); end
      if (mem_addr !== 32'h0)         begin bad++; $display("FAIL idle_addr got=%h want=0", mem_addr); end
      if (mem_wdata !== 32'h0)        begin bad++; $display("FAIL idle_wdata got=%h want=0", mem_wdata); end
      next_cycle();
    end
  endtask

  task automatic test_fixed_priority();
    logic [31:0] fexp[$];
    logic [31:0] want;
    for (int i = 0; i < 4; i++) begin
      f0_rstrb = 1'b1; f0_addr = 32'h30 + 32'(4 * i);
      f1_wmask = 4'hF; f1_addr = 32'h40; f1_wdata = 32'hDEAD_BEEF;
      #2;
      want = (fexp.size() > 0) ? fexp.pop_front() : 32'h0;
      total += 5;
      if ({f0_gnt, f1_gnt} !== 2'b10) begin bad++; $display("FAIL fp_gnt i=%0d got=%b want=10", i, {f0_gnt, f1_gnt}); end
      if (f_mem_addr !== f0_addr)     begin bad++; $display("FAIL fp_addr i=%0d got=%h want=%h", i, f_mem_addr, f0_addr); end
      if (f_mem_wmask !== 4'h0)       begin bad++; $display("FAIL fp_wmask i=%0d got=%h want=0", i, f_mem_wmask); end
      if (f0_rvalid !== (i > 0))      begin bad++; $display("FAIL fp_rv i=%0d got=%b want=%b", i, f0_rvalid, i > 0); end
      if (f0_rdata !== want)          begin bad++; $display("FAIL fp_rdata i=%0d got=%h want=%h", i, f0_rdata, want); end
      fexp.push_back(32'h600D_F00D);
      next_cycle();
    end
    f0_rstrb = 1'b0; f0_addr = '0;
    #2;
    total += 6;
    if ({f0_gnt, f1_gnt} !== 2'b01)    begin bad++; $display("FAIL fpw_gnt got=%b want=01", {f0_gnt, f1_gnt}); end
    if (f_mem_wmask !== 4'hF)          begin bad++; $display("FAIL fpw_wmask got=%h want=f", f_mem_wmask); end
    if (f_mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fpw_wdata got=%h want=deadbeef", f_mem_wdata); end
    if (f_mem_addr !== 32'h40)         begin bad++; $display("FAIL fpw_addr got=%h want=40", f_mem_addr); end
    if (f0_rvalid !== 1'b1)            begin bad++; $display("FAIL fpw_rv got=%b want=1", f0_rvalid); end
    if (f0_rdata !== fexp.pop_front()) begin bad++; $display("FAIL fpw_rdata got=%h want=600df00d", f0_rdata); end
    next_cycle();
    idle_inputs();
    #2;
    total++;
    if ({f0_rvalid, f1_rvalid} !== 2'b00) begin bad++; $display("FAIL fp_norv got=%b want=00", {f0_rvalid, f1_rvalid}); end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    for (int i = 0; i < 64; i++) exp_mem[i] = seed(i);
    next_cycle();
    mon_en = 1'b1;
    test_reset();
    test_first_tie();
    test_alternate();
    test_byte_write();
    test_reset_abort();
    test_idle();
    test_fixed_priority();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
